// File: rtl/predictor_pkg.sv
// predictor_pkg: default widths and FSM encoding shared by the
// predictor MAC accumulator and its output stage.
package predictor_pkg;

    localparam int PROD_WIDTH_DEF = 96;
    localparam int OUT_WIDTH_DEF  = 64;
    localparam int FRAC_BITS_DEF  = 32;
    localparam int ACC_GUARD_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/predictor_acc_sat.sv
// predictor_acc_sat: combinational fixed-point shift and width reduction.
// Clamping to the signed output range is compiled in with PRED_ACC_SAT_EN.
module predictor_acc_sat
    import predictor_pkg::*;
#(
    parameter int ACC_WIDTH = PROD_WIDTH_DEF + ACC_GUARD_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] res,
    output logic                        sat
);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [OUT_WIDTH-1:0] low;

    assign shifted = sum >>> FRAC_BITS;
    assign low     = shifted[OUT_WIDTH-1:0];

`ifdef PRED_ACC_SAT_EN
    logic signed [ACC_WIDTH-1:0] low_ext;
    logic                        fits;

    // In range exactly when sign-extending the low bits rebuilds the value.
    assign low_ext = {{(ACC_WIDTH-OUT_WIDTH){low[OUT_WIDTH-1]}}, low};
    assign fits    = (low_ext == shifted);

    always_comb begin
        res = low;
        sat = 1'b0;
        if (!fits) begin
            sat = 1'b1;
            if (shifted[ACC_WIDTH-1])
                res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            else
                res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[ACC_WIDTH-1:OUT_WIDTH];
    assign res       = low;
    assign sat       = 1'b0;
`endif

endmodule

// File: rtl/predictor_mac_acc.sv
// predictor_mac_acc: dot-product accumulator behind a pipelined multiplier.
// Optional output clamping: define PRED_ACC_SAT_EN.
module predictor_mac_acc
    import predictor_pkg::*;
#(
    parameter int PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int ACC_GUARD  = ACC_GUARD_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         prod_valid,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_last,
    output logic                         prod_ready,
    output logic                         out_valid,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    input  logic                         out_ready,
    output logic                         sat_flag,
    output logic                         drop_err
);

    localparam int ACC_WIDTH = PROD_WIDTH + ACC_GUARD;

    state_t state;
    state_t state_nx;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] term;
    logic signed [ACC_WIDTH-1:0] acc_nx;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        res_sat;
    logic                        accept;
    logic                        done;
    logic                        drop;
    logic                        release_ok;

    assign term       = {{ACC_GUARD{prod_data[PROD_WIDTH-1]}}, prod_data};
    assign accept     = ce && prod_valid && (state != HOLD);
    assign done       = accept && prod_last;
    assign drop       = ce && prod_valid && (state == HOLD);
    assign release_ok = (state == HOLD) && out_ready;
    assign prod_ready = (state != HOLD);

    // First term of a vector loads directly, so no clear cycle is needed.
    assign acc_nx = (state == IDLE) ? term : acc + term;

    predictor_acc_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .sum (acc_nx),
        .res (res),
        .sat (res_sat)
    );

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == HOLD): if (out_ready) state_nx = IDLE;
            accept:          state_nx = prod_last ? HOLD : ACCUM;
            default:         state_nx = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept)
                acc <= acc_nx;
            if (done) begin
                out_valid <= 1'b1;
                out_data  <= res;
                sat_flag  <= res_sat;
            end else if (release_ok) begin
                out_valid <= 1'b0;
            end
            if (drop)
                drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_predictor_mac_acc.sv
// tb_predictor_mac_acc: directed and randomized checks of predictor_mac_acc
// against a sum-of-terms reference model.
module tb_predictor_mac_acc;

    localparam logic signed [103:0] MAXV = 104'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [103:0] MINV = -104'sh8000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               prod_valid;
    logic signed [95:0] prod_data;
    logic               prod_last;
    logic               prod_ready;
    logic               out_valid;
    logic signed [63:0] out_data;
    logic               out_ready;
    logic               sat_flag;
    logic               drop_err;

    int total = 0;
    int bad   = 0;

    predictor_mac_acc dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic void model(input logic signed [103:0] s,
                                  output logic [63:0] d,
                                  output logic f);
        logic signed [103:0] q;
        q = s >>> 32;
        d = q[63:0];
        f = 1'b0;
`ifdef PRED_ACC_SAT_EN
        if (q > MAXV) begin
            d = 64'h7FFF_FFFF_FFFF_FFFF;
            f = 1'b1;
        end else if (q < MINV) begin
            d = 64'h8000_0000_0000_0000;
            f = 1'b1;
        end
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ce         = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_last  = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic feed(input logic signed [95:0] d, input logic l);
        ce         = 1'b1;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = l;
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || sat_flag !== 1'b0 ||
            drop_err !== 1'b0 || prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_vals got v=%b d=%h s=%b e=%b r=%b exp 0 0 0 0 1",
                     out_valid, out_data, sat_flag, drop_err, prod_ready);
        end
        reset = 1'b0;
        feed(96'sh5_0000_0000, 1'b1);
        total++;
        if (out_valid !== 1'b1 || prod_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_pre_hold got v=%b r=%b exp 1 0", out_valid, prod_ready);
        end
        reset = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1 || out_data !== 64'd0) begin
            bad++;
            $display("FAIL reset_async got v=%b r=%b d=%h exp 0 1 0",
                     out_valid, prod_ready, out_data);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        feed(96'sh3_0000_0000, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_valid got=%b exp=0", out_valid);
        end
        feed(96'sh5_0000_0000, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'd8 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got v=%b d=%h s=%b exp v=1 d=8 s=0",
                     out_valid, out_data, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release got v=%b r=%b exp 0 1", out_valid, prod_ready);
        end
    endtask

    task automatic test_floor();
        do_reset();
        feed(-96'sd1, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== -64'sd1) begin
            bad++;
            $display("FAIL floor_m1 got v=%b d=%h exp v=1 d=ffffffffffffffff",
                     out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        feed(-96'sh7_0000_0000, 1'b1);
        total++;
        if (out_data !== -64'sd7 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL floor_m7 got d=%h s=%b exp d=fffffffffffffff9 s=0",
                     out_data, sat_flag);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_sat();
        logic [63:0] ed;
        logic        ef;
`ifdef PRED_ACC_SAT_EN
        ed = 64'h7FFF_FFFF_FFFF_FFFF;
        ef = 1'b1;
`else
        ed = 64'h8000_0000_0000_0000;
        ef = 1'b0;
`endif
        do_reset();
        feed(96'sh4000_0000_0000_0000_0000_0000, 1'b0);
        feed(96'sh4000_0000_0000_0000_0000_0000, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== ed || sat_flag !== ef) begin
            bad++;
            $display("FAIL sat_big got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                     out_valid, out_data, sat_flag, ed, ef);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        feed(96'sh9_0000_0000, 1'b1);
        ce         = 1'b1;
        prod_valid = 1'b1;
        prod_data  = 96'sh77_0000_0000;
        prod_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== 64'd9 ||
                prod_ready !== 1'b0 || drop_err !== 1'b1) begin
                bad++;
                $display("FAIL hold_cyc%0d got v=%b d=%h r=%b e=%b exp 1 9 0 1",
                         i, out_valid, out_data, prod_ready, drop_err);
            end
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        out_ready  = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1 || drop_err !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got v=%b r=%b e=%b exp 0 1 1",
                     out_valid, prod_ready, drop_err);
        end
        feed(96'sh2_0000_0000, 1'b1);
        total++;
        if (out_data !== 64'd2) begin
            bad++;
            $display("FAIL hold_next_vec got=%h exp=2", out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(96'sh11_0000_0000, 1'b0);
        feed(96'sh22_0000_0000, 1'b0);
        reset = 1'b1;
        #2;
        total++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got r=%b v=%b exp 1 0", prod_ready, out_valid);
        end
        step();
        reset = 1'b0;
        feed(96'sh1_0000_0000, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'd1) begin
            bad++;
            $display("FAIL rstmid_result got v=%b d=%h exp v=1 d=1", out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_ce();
        do_reset();
        feed(96'sh4_0000_0000, 1'b0);
        ce         = 1'b0;
        prod_valid = 1'b1;
        prod_data  = 96'sh64_0000_0000;
        prod_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
                bad++;
                $display("FAIL ce_gap%0d got v=%b r=%b exp 0 1", i, out_valid, prod_ready);
            end
        end
        feed(96'sh6_0000_0000, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'd10) begin
            bad++;
            $display("FAIL ce_result got v=%b d=%h exp v=1 d=a", out_valid, out_data);
        end
        ce        = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        ce        = 1'b1;
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            bad++;
            $display("FAIL ce_release got v=%b r=%b exp 0 1", out_valid, prod_ready);
        end
    endtask

    task automatic test_random();
        logic signed [103:0] s;
        logic signed [95:0]  t;
        logic [63:0]         ed;
        logic                ef;
        int                  n;
        int                  gaps;
        int                  hold;
        do_reset();
        for (int v = 0; v < 60; v++) begin
            n = $urandom_range(1, 8);
            s = '0;
            for (int k = 0; k < n; k++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    ce         = $urandom_range(0, 1);
                    prod_valid = !ce && ($urandom_range(0, 1) == 1);
                    prod_data  = $signed({$urandom(), $urandom(), $urandom()});
                    prod_last  = $urandom_range(0, 1);
                    step();
                    total++;
                    if (out_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd_gap v%0d got=%b exp=0", v, out_valid);
                    end
                end
                t = $signed({$urandom(), $urandom(), $urandom()}) >>> $urandom_range(0, 95);
                s = s + {{8{t[95]}}, t};
                feed(t, k == n - 1);
            end
            model(s, ed, ef);
            total++;
            if (out_valid !== 1'b1 || out_data !== ed || sat_flag !== ef) begin
                bad++;
                $display("FAIL rnd_result v%0d got v=%b d=%h s=%b exp v=1 d=%h s=%b",
                         v, out_valid, out_data, sat_flag, ed, ef);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                ce         = $urandom_range(0, 1);
                prod_valid = 1'b0;
                step();
                total++;
                if (out_valid !== 1'b1 || out_data !== ed || prod_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_hold v%0d got v=%b d=%h r=%b exp v=1 d=%h r=0",
                             v, out_valid, out_data, prod_ready, ed);
                end
            end
            ce         = $urandom_range(0, 1);
            prod_valid = 1'b0;
            out_ready  = 1'b1;
            step();
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
                bad++;
                $display("FAIL rnd_release v%0d got v=%b r=%b exp 0 1",
                         v, out_valid, prod_ready);
            end
        end
        total++;
        if (drop_err !== 1'b0) begin
            bad++;
            $display("FAIL rnd_drop_err got=%b exp=0", drop_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        test_reset();
        test_basic();
        test_floor();
        test_sat();
        test_hold();
        test_reset_mid();
        test_ce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/predictor_mac_acc.md
PREDICTOR_MAC_ACC -- requirements
Module: predictor_mac_acc

Interface
REQ-001 The block SHALL have parameter PROD_WIDTH, default 96: signed product width from the upstream pipelined multiplier.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 64: signed result width.
REQ-003 The block SHALL have parameter FRAC_BITS, default 32: right shift applied to the final sum.
REQ-004 The block SHALL have parameter ACC_GUARD, default 8: extra accumulator bits; accumulator width is PROD_WIDTH+ACC_GUARD.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port ce, input, 1: clock enable for the accumulation path.
REQ-008 The block SHALL have port prod_valid, input, 1: prod_data holds a term.
REQ-009 The block SHALL have port prod_data, input, PROD_WIDTH: signed product term.
REQ-010 The block SHALL have port prod_last, input, 1: the current term is the last of the dot product.
REQ-011 The block SHALL have port prod_ready, output, 1: high when not in HOLD; the controller gates multiplier ce with it.
REQ-012 The block SHALL have port out_valid, output, 1: result valid.
REQ-013 The block SHALL have port out_data, output, OUT_WIDTH: signed result.
REQ-014 The block SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 The block SHALL have port sat_flag, output, 1: the current result was clamped.
REQ-016 The block SHALL have port drop_err, output, 1: sticky flag; a term arrived while prod_ready was low.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-018 An accepted term is one with ce=1, prod_valid=1 and state not HOLD.
REQ-019 In IDLE, an accepted term SHALL load acc with sign-extended prod_data: the first-term bypass, with no separate clear cycle.
REQ-020 In ACCUM, an accepted term SHALL set acc to acc + sext(prod_data).
REQ-021 An accepted term with prod_last=0 SHALL go to or stay in ACCUM; with prod_last=1 it SHALL go to HOLD.
REQ-022 A single-term vector (first and last term in the same cycle) SHALL be legal.
REQ-023 out_valid SHALL rise exactly 1 cycle after the cycle that accepts the last term.
REQ-024 out_data SHALL be (final sum >>> FRAC_BITS): arithmetic shift, truncation toward -infinity, then width-reduced per REQ-032/REQ-033.
REQ-025 In HOLD, out_data, out_valid and sat_flag SHALL be stable until out_ready=1.
REQ-026 With out_ready=1 in HOLD, the next state SHALL be IDLE and out_valid SHALL fall; this happens regardless of ce.
REQ-027 prod_ready SHALL be 0 exactly while in HOLD.
REQ-028 ce=0 SHALL freeze acc and the FSM, except for the HOLD-to-IDLE transition.
REQ-029 prod_valid=1 with ce=1 in HOLD SHALL be dropped and SHALL set drop_err.
REQ-030 The accumulator SHALL wrap modulo 2^(PROD_WIDTH+ACC_GUARD) with no internal overflow detection; the caller guarantees at most 2^ACC_GUARD terms.

Reset
REQ-031 Reset assertion SHALL, asynchronously at any time, set state IDLE, acc 0, out_valid 0, out_data 0, sat_flag 0, drop_err 0 and prod_ready 1; a partial sum is discarded.

Configuration
REQ-032 With PRED_ACC_SAT_EN defined, a shifted sum outside the signed OUT_WIDTH range SHALL clamp to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1) and set sat_flag for that result.
REQ-033 Without PRED_ACC_SAT_EN, out_data SHALL be the low OUT_WIDTH bits (wrap) and sat_flag SHALL be tied to 0.

Structure
REQ-034 Package predictor_pkg SHALL hold the PROD_WIDTH, OUT_WIDTH and FRAC_BITS defaults and the FSM state enum.
REQ-035 Sub-module predictor_acc_sat SHALL be the combinational shift-and-saturate stage; the saturation part is compiled under PRED_ACC_SAT_EN.

Verification
REQ-036 Terms 3<<32, 5<<32 (last) SHALL give out_data=8 one cycle after the last term, with sat_flag=0.
REQ-037 A single term -1 (raw, last) SHALL give out_data=-1 (floor); a term -7<<32 SHALL give -7.
REQ-038 Two terms of 2^94 each, with the macro defined, SHALL give out_data=0x7FFF_FFFF_FFFF_FFFF and sat_flag=1; without the macro, out_data=0x8000_0000_0000_0000 and sat_flag=0.
REQ-039 out_ready held low 3 cycles in HOLD, with prod_valid=1 and ce=1 meanwhile, SHALL keep out_data held and prod_ready=0, and SHALL set drop_err=1 (sticky); out_ready=1 SHALL return the FSM to IDLE.
REQ-040 Reset asserted mid-ACCUM after 2 terms, then terms 1<<32 (last), SHALL give out_data=1.
REQ-041 ce=0 for 2 cycles between terms 4<<32 and 6<<32 (last) SHALL give out_data=10, with the valid term ignored while ce=0.
